// File: rtl/dsp_dot_sequencer.sv
// Issue sequencer for a DSP48A1 slice computing a dot product in its post-adder.
// Streams operand pairs into the slice, waits out the pipeline, then returns P.
module dsp_dot_sequencer #(
  parameter int DSP_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [17:0]      i_in_a,
  input  logic [17:0]      i_in_b,
  input  logic             i_in_last,
  output logic [17:0]      o_dsp_a,
  output logic [17:0]      o_dsp_b,
  output logic [17:0]      o_dsp_d,
  output logic [47:0]      o_dsp_c,
  output logic [7:0]       o_dsp_opmode,
  output logic             o_dsp_ce,
  output logic             o_dsp_rst,
  input  logic [47:0]      i_dsp_p,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [47:0]      o_out_result,
  output logic [CNT_W-1:0] o_out_count
);

  localparam int DW = $clog2(DSP_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_in_ready;
  logic [17:0]      r_dsp_a;
  logic [17:0]      r_dsp_b;
  logic [7:0]       r_slot_op;
  logic [7:0]       r_dsp_opmode;
  logic             r_dsp_ce;
  logic             r_dsp_rst;
  logic [DW-1:0]    r_drain_cnt;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [47:0]      r_out_result;
  logic [CNT_W-1:0] r_out_count;

  logic             w_accept;
  logic             w_drain_done;
  logic             w_in_ready_nxt;
  logic [7:0]       w_slot_op_nxt;
  logic [DW-1:0]    w_drain_cnt_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_out_valid_nxt;
  logic [47:0]      w_out_result_nxt;
  logic [CNT_W-1:0] w_out_count_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign w_accept     = i_in_valid & r_in_ready;
  assign w_drain_done = (r_state == S_DRAIN) && (r_drain_cnt == DW'(DSP_LAT));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = i_in_last ? S_DRAIN : S_ACC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACC: begin
        if (w_accept && i_in_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_ACC;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (r_out_valid && i_out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and bookkeeping
  always_comb begin
    w_in_ready_nxt   = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACC);
    w_count_nxt      = r_count;
    w_drain_cnt_nxt  = {DW{1'b0}};
    w_out_valid_nxt  = r_out_valid;
    w_out_result_nxt = r_out_result;
    w_out_count_nxt  = r_out_count;
    // Any slot issued while IDLE restarts the sum; every other slot accumulates.
    if (r_state == S_IDLE) begin
      w_slot_op_nxt = 8'h01;
    end else begin
      w_slot_op_nxt = 8'h09;
    end
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_count_nxt = r_count;
        end
      end
      S_ACC: begin
        if (w_accept) begin
          w_count_nxt = sat_inc(r_count);
        end else begin
          w_count_nxt = r_count;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          w_out_valid_nxt  = 1'b1;
          w_out_result_nxt = i_dsp_p;
          w_out_count_nxt  = r_count;
        end else begin
          w_drain_cnt_nxt  = r_drain_cnt + DW'(1);
        end
      end
      S_HOLD: begin
        if (r_out_valid && i_out_ready) begin
          w_out_valid_nxt = 1'b0;
        end else begin
          w_out_valid_nxt = r_out_valid;
        end
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  // Registered slice drive, result capture and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_ready   <= 1'b0;
      r_dsp_a      <= 18'd0;
      r_dsp_b      <= 18'd0;
      r_slot_op    <= 8'h00;
      r_dsp_opmode <= 8'h00;
      r_dsp_ce     <= 1'b0;
      r_dsp_rst    <= 1'b1;
      r_drain_cnt  <= {DW{1'b0}};
      r_count      <= {CNT_W{1'b0}};
      r_out_valid  <= 1'b0;
      r_out_result <= 48'd0;
      r_out_count  <= {CNT_W{1'b0}};
    end else begin
      r_in_ready   <= w_in_ready_nxt;
      r_dsp_a      <= w_accept ? i_in_a : 18'd0;
      r_dsp_b      <= w_accept ? i_in_b : 18'd0;
      // Opmode trails its operands by one edge to meet the slice's M stage.
      r_slot_op    <= w_slot_op_nxt;
      r_dsp_opmode <= r_slot_op;
      r_dsp_ce     <= 1'b1;
      r_dsp_rst    <= 1'b0;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_count      <= w_count_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_result <= w_out_result_nxt;
      r_out_count  <= w_out_count_nxt;
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_dsp_a      = r_dsp_a;
  assign o_dsp_b      = r_dsp_b;
  assign o_dsp_d      = 18'd0;
  assign o_dsp_c      = 48'd0;
  assign o_dsp_opmode = r_dsp_opmode;
  assign o_dsp_ce     = r_dsp_ce;
  assign o_dsp_rst    = r_dsp_rst;
  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_out_result;
  assign o_out_count  = r_out_count;

endmodule

// File: tb/tb_dsp_dot_sequencer.sv
// Directed bench for dsp_dot_sequencer with a behavioural DSP48A1 slice
// (A1/B1 -> M -> P, registered opmode) attached to the sequencer's slice ports.
module tb_dsp_dot_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic             in_last;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [17:0]      dsp_d;
  logic [47:0]      dsp_c;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic             dsp_rst;
  logic [47:0]      dsp_p;
  logic             out_valid;
  logic             out_ready;
  logic [47:0]      out_result;
  logic [CNT_W-1:0] out_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dsp_dot_sequencer #(.DSP_LAT(3), .CNT_W(CNT_W)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_a       (in_a),
    .i_in_b       (in_b),
    .i_in_last    (in_last),
    .o_dsp_a      (dsp_a),
    .o_dsp_b      (dsp_b),
    .o_dsp_d      (dsp_d),
    .o_dsp_c      (dsp_c),
    .o_dsp_opmode (dsp_opmode),
    .o_dsp_ce     (dsp_ce),
    .o_dsp_rst    (dsp_rst),
    .i_dsp_p      (dsp_p),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_result (out_result),
    .o_out_count  (out_count)
  );

  // Slice model: A1REG/B1REG, MREG, OPMODEREG, PREG; X=M when opmode[1:0]=01, Z=P when opmode[3:2]=10
  logic signed [17:0] s_a1;
  logic signed [17:0] s_b1;
  logic signed [35:0] s_m;
  logic [7:0]         s_opm;
  logic [47:0]        s_p;

  always @(posedge clk) begin
    if (dsp_rst) begin
      s_a1  <= 18'sd0;
      s_b1  <= 18'sd0;
      s_m   <= 36'sd0;
      s_opm <= 8'h00;
      s_p   <= 48'd0;
    end else if (dsp_ce) begin
      s_a1  <= signed'(dsp_a);
      s_b1  <= signed'(dsp_b);
      s_m   <= s_a1 * s_b1;
      s_opm <= dsp_opmode;
      s_p   <= ((s_opm[3:2] == 2'b10) ? s_p : 48'd0) +
               ((s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0);
    end
  end
  assign dsp_p = s_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a beat from a negedge and return at the negedge after it is accepted.
  task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("beat_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = 18'd0;
    in_b     = 18'd0;
  endtask

  task automatic wait_result(input string tag, input logic [47:0] er, input logic [15:0] ec);
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      check({tag, "_inrdy_low"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(out_result), 64'(er));
    check({tag, "_count"}, 64'(out_count), 64'(ec));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_hs_valid_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_hs_inrdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_dsp_a"}, 64'(dsp_a), 64'd0);
    check({tag, "_dsp_b"}, 64'(dsp_b), 64'd0);
    check({tag, "_dsp_d"}, 64'(dsp_d), 64'd0);
    check({tag, "_dsp_c"}, 64'(dsp_c), 64'd0);
    check({tag, "_opmode"}, 64'(dsp_opmode), 64'd0);
    check({tag, "_ce"}, 64'(dsp_ce), 64'd0);
    check({tag, "_rst"}, 64'(dsp_rst), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_result"}, 64'(out_result), 64'd0);
    check({tag, "_out_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    logic [47:0] sum;
    int          len;
    logic [17:0] ra;
    logic [17:0] rb;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 18'd0;
    in_b      = 18'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_ce", 64'(dsp_ce), 64'd1);
    check("rel_rst", 64'(dsp_rst), 64'd0);
    @(negedge clk);

    // Single beat: valid appears exactly four edges after the accept edge
    send_beat(18'd3, 18'd4, 1'b1);
    check("single_inrdy_low", 64'(in_ready), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("single_lat_e%0d", k), 64'(out_valid), (k == 4) ? 64'd1 : 64'd0);
    end
    wait_result("single", 48'd12, 16'd1);
    handshake("single");

    // Back-to-back: 1*5+2*6+3*7+4*8 = 70
    for (int i = 1; i <= 4; i++) send_beat(18'(i), 18'(i + 4), i == 4);
    wait_result("b2b", 48'd70, 16'd4);
    handshake("b2b");

    // Two bubbles between beats 2 and 3
    send_beat(18'd1, 18'd5, 1'b0);
    send_beat(18'd2, 18'd6, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(18'd3, 18'd7, 1'b0);
    send_beat(18'd4, 18'd8, 1'b1);
    wait_result("bubble", 48'd70, 16'd4);
    handshake("bubble");

    // Backpressure, then a fresh vector must not include the old sum
    for (int i = 1; i <= 4; i++) send_beat(18'(i), 18'(i + 4), i == 4);
    wait_result("bp", 48'd70, 16'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(out_result), 64'd70);
      check("bp_hold_inrdy", 64'(in_ready), 64'd0);
    end
    handshake("bp");
    send_beat(18'd2, 18'd10, 1'b1);
    wait_result("bp_next", 48'd20, 16'd1);
    handshake("bp_next");

    // Reset in the middle of a vector
    send_beat(18'd1, 18'd5, 1'b0);
    send_beat(18'd2, 18'd6, 1'b0);
    rst_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send_beat(18'd1000, 18'd1000, 1'b1);
    wait_result("postrst", 48'd1000000, 16'd1);
    handshake("postrst");

    // Random vectors against a sum-of-products reference
    for (int v = 0; v < 20; v++) begin
      len = $urandom_range(1, 8);
      sum = 48'd0;
      for (int j = 0; j < len; j++) begin
        ra  = 18'($urandom_range(0, 1000));
        rb  = 18'($urandom_range(0, 1000));
        sum = sum + 48'(ra) * 48'(rb);
        send_beat(ra, rb, j == len - 1);
        if (j < len - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_result($sformatf("rand%0d", v), sum, 16'(len));
      handshake($sformatf("rand%0d", v));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dsp_dot_sequencer.md
# dsp_dot_sequencer

Upstream controller for the team's DSP48A1 slice. It accepts a stream of operand pairs over a valid/ready handshake and drives the slice's A/B/D/C/OPMODE/CE/RST ports so that the slice computes a dot product in its post-adder. It tracks the slice's fixed pipeline latency and returns each finished sum from P over a valid/ready output. The slice is configured with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMODE5".

## Interface
- DSP_LAT, 3, edges from operands present at slice input to product accumulated in P; fixed for the slice configuration above
- CNT_W, 16, width of beat counter OUT_COUNT
- CLK  input  1  single clock, rising edge
- RST_N  input  1  reset, asynchronous, active-low
- IN_VALID  input  1  operand beat valid
- IN_READY  output  1  sequencer can accept a beat
- IN_A  input  18  operand to slice A
- IN_B  input  18  operand to slice B
- IN_LAST  input  1  final beat of current vector
- DSP_A, DSP_B, DSP_D  output  18  registered slice operands; DSP_D tied 0
- DSP_C  output  48  tied 0
- DSP_OPMODE  output  8  registered slice opmode
- DSP_CE  output  1  all slice clock enables; constant 1 out of reset
- DSP_RST  output  1  all slice resets, active-high
- DSP_P  input  48  slice P
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  consumer accepts result
- OUT_RESULT  output  48  dot product
- OUT_COUNT  output  CNT_W  beats in the vector, saturating at all-ones

## Operation
- Reset values: IN_READY=0, DSP_A/B/D/C=0, DSP_OPMODE=8'h00, DSP_CE=0, DSP_RST=1, OUT_VALID=0, OUT_RESULT=0, OUT_COUNT=0. The state is IDLE.
- DSP_RST deasserts and DSP_CE asserts at the first CLK edge after RST_N rises. IN_READY rises at that same edge.
- Each cycle is an issue slot. On an accepted beat (IN_VALID&IN_READY), DSP_A/DSP_B load IN_A/IN_B. In any other cycle they load 0, which gives a zero product (bubble).
- The opmode for a slot is registered one edge after the slot's operands:
  - first beat of a vector: 8'h01 (X=M, Z=0, pre-adder bypass, carry 0)
  - all later slots, including bubbles and drain slots: 8'h09 (X=M, Z=P)
  - IDLE with no beat: 8'h01
- States:
  - IDLE: IN_READY=1. An accepted beat sets count=1, loads the first-beat opmode and moves to ACC. If that beat also has IN_LAST, go to DRAIN instead.
  - ACC: IN_READY=1. Each accepted beat increments count (saturating). An accepted beat with IN_LAST goes to DRAIN.
  - DRAIN: IN_READY=0. Bubbles issue for DSP_LAT+1 edges after the last-beat accept edge. At that final edge, OUT_RESULT<=DSP_P, OUT_COUNT<=count, OUT_VALID<=1, and the state moves to HOLD.
  - HOLD: IN_READY=0. OUT_RESULT and OUT_COUNT stay stable. When OUT_VALID&OUT_READY, clear OUT_VALID and go to IDLE.
- Vectors never overlap. A new vector starts only after the output handshake completes.
- Arithmetic: the full 48-bit sum from the slice is reported unchanged, with no saturation or rounding.
- Reset mid-operation: asserting RST_N low clears all state immediately to reset values. The partial vector is discarded.

## Timing
- Beat accepted at edge e0:
  - DSP_A/B valid after e0
  - slice A1/B1 capture at e1, M at e2
  - opmode registered by the sequencer at e1, by the slice at e2
  - P updated at e3
- Back-to-back beats accumulate with no stalls: beat k's M meets beat k-1's P in the same post-adder cycle.
- Last beat accepted at edge e0 → OUT_VALID high after e4 (DSP_LAT+1).
- Minimum vector period: N beats + 4 drain cycles + 1 handshake cycle.
- Bubbles inside a vector add 0 and do not change the result.

## Test plan
- Single beat: A=3, B=4, LAST=1 → OUT_VALID high 4 edges after accept, OUT_RESULT=12, OUT_COUNT=1.
- Back-to-back: A=1..4, B=5..8, LAST on beat 4 → OUT_RESULT=70, OUT_COUNT=4. IN_READY stays low from the last accept until the output handshake.
- Bubbles: same vector as back-to-back with IN_VALID low for 2 cycles between beats 2 and 3 → OUT_RESULT=70, OUT_COUNT=4.
- Backpressure: OUT_READY low for 5 cycles after OUT_VALID → OUT_RESULT and OUT_VALID hold, IN_READY=0. Release OUT_READY → IDLE next edge, and a following vector A=2, B=10 gives 20, not 90.
- Reset mid-vector: assert RST_N low after beat 2 of 4 → all outputs return to reset values asynchronously. After release, vector A=1000, B=1000 gives 1000000, OUT_COUNT=1.
- Random: 20 vectors of length 1-8 with operands 0-1000 and random bubbles → every OUT_RESULT matches a reference sum of products.
